// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: hart request/completion and RAM strobe/bus signals of the four-hart RAM port arbiter.
interface ram_port_arbiter_if;
    logic [3:0]       Req;
    logic [3:0]       ReqWrite;
    logic [3:0][31:0] ReqAddr;
    logic [3:0][31:0] ReqWData;
    logic [3:0]       Grant;
    logic [3:0]       Done;
    logic [1:0]       DoneForTID;
    logic [31:0]      RdData;
    logic             RamRead;
    logic             RamWrite;
    logic [31:0]      RamReadAddress;
    logic [31:0]      RamWriteAddress;
    logic [31:0]      RamWriteData;
    logic [31:0]      RamData;

    modport master (
        output Req, ReqWrite, ReqAddr, ReqWData, RamData,
        input  Grant, Done, DoneForTID, RdData, RamRead, RamWrite,
               RamReadAddress, RamWriteAddress, RamWriteData
    );

    modport slave (
        input  Req, ReqWrite, ReqAddr, ReqWData, RamData,
        output Grant, Done, DoneForTID, RdData, RamRead, RamWrite,
               RamReadAddress, RamWriteAddress, RamWriteData
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter sharing one RAM port among four harts, one access per RAM_LATENCY+2 cycles.
// Defining ARB_WRPRIO_EN makes pending writes win over pending reads.
module ram_port_arbiter #(
    parameter int RAM_LATENCY = 4
) (
    input  logic               clk,
    input  logic               Reset,
    ram_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] tid;
    logic [1:0] pick;
    logic [3:0] cnt;
    logic [3:0] cand;
    logic       is_wr;

`ifdef ARB_WRPRIO_EN
    assign cand = |(bus.Req & bus.ReqWrite) ? (bus.Req & bus.ReqWrite) : bus.Req;
`else
    assign cand = bus.Req;
`endif

    // ptr holds the hart where the next search starts; descending scan leaves the nearest candidate
    always_comb begin
        pick = ptr;
        for (int i = 3; i >= 0; i--)
            if (cand[ptr + 2'(i)]) pick = ptr + 2'(i);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state               <= IDLE;
            ptr                 <= '0;
            cnt                 <= '0;
            tid                 <= '0;
            is_wr               <= 1'b0;
            bus.Grant           <= '0;
            bus.Done            <= '0;
            bus.DoneForTID      <= '0;
            bus.RdData          <= '0;
            bus.RamRead         <= 1'b0;
            bus.RamWrite        <= 1'b0;
            bus.RamReadAddress  <= '0;
            bus.RamWriteAddress <= '0;
            bus.RamWriteData    <= '0;
        end else begin
            case (state)
                IDLE: if (|bus.Req) begin
                    state               <= ACCESS;
                    tid                 <= pick;
                    is_wr               <= bus.ReqWrite[pick];
                    cnt                 <= 4'(RAM_LATENCY - 1);
                    bus.Grant           <= 4'b1 << pick;
                    bus.RamRead         <= !bus.ReqWrite[pick];
                    bus.RamWrite        <= bus.ReqWrite[pick];
                    bus.RamReadAddress  <= bus.ReqWrite[pick] ? '0 : bus.ReqAddr[pick];
                    bus.RamWriteAddress <= bus.ReqWrite[pick] ? bus.ReqAddr[pick] : '0;
                    bus.RamWriteData    <= bus.ReqWrite[pick] ? bus.ReqWData[pick] : '0;
                end
                ACCESS: if (cnt == 4'd0) begin
                    state               <= DONE;
                    bus.Grant           <= '0;
                    bus.RamRead         <= 1'b0;
                    bus.RamWrite        <= 1'b0;
                    bus.RamReadAddress  <= '0;
                    bus.RamWriteAddress <= '0;
                    bus.RamWriteData    <= '0;
                    bus.Done            <= 4'b1 << tid;
                    bus.DoneForTID      <= tid;
                    if (!is_wr) bus.RdData <= bus.RamData;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                DONE: begin
                    state          <= IDLE;
                    bus.Done       <= '0;
                    bus.DoneForTID <= '0;
                    ptr            <= tid + 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
